mem_bus_arbiter_n: RTL and testbench
====================================

MEM_BUS_ARBITER_N -- requirements
Module: mem_bus_arbiter_n

Interface
REQ-001 Parameter NUM_PORTS, 4, number of requesters (2..8); port 0 = IFetch, port 1 = MMU by convention.
REQ-002 Parameter ADDR_WIDTH, 32, address width.
REQ-003 Parameter DATA_WIDTH, 32, data width.
REQ-004 Parameter TIMEOUT_CYCLES, 255, max RX wait before error (1..65535).
REQ-005 clk  in  1  clock; all logic on rising edge.
REQ-006 reset  in  1  reset, synchronous, active-high.
REQ-007 flush  in  1  system flush; abort outstanding transaction.
REQ-008 stall  in  1  system stall; freeze FSM, counter and pointer.
REQ-009 req_valid  in  NUM_PORTS  per-port request.
REQ-010 req_addr  in  NUM_PORTS*ADDR_WIDTH  flattened addresses, port i at [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-011 req_we  in  NUM_PORTS  per-port write enable.
REQ-012 req_wdata  in  NUM_PORTS*DATA_WIDTH  flattened write data.
REQ-013 req_grant  out  NUM_PORTS  one-hot grant pulse.
REQ-014 rsp_valid  out  NUM_PORTS  one-hot completion pulse (read data or write ack).
REQ-015 rsp_err  out  1  completion was a timeout; valid with rsp_valid.
REQ-016 rsp_rdata  out  DATA_WIDTH  read data, shared by all ports.
REQ-017 mem_req_valid, mem_addr, mem_we, mem_wdata  out  1/ADDR_WIDTH/1/DATA_WIDTH  memory bus request.
REQ-018 mem_rdata, mem_data_valid  in  DATA_WIDTH/1  memory bus response.

Function
REQ-019 FSM states IDLE, TX, RX, DONE; IDLE->TX when any req_valid and !stall; TX->RX unconditionally; RX->DONE on mem_data_valid or timeout; DONE->IDLE.
REQ-020 In IDLE with any req_valid and !stall, exactly one req_grant bit is high that cycle (combinational); winner's addr/we/wdata and index are registered on that edge.
REQ-021 mem_req_valid is high in TX and RX, low otherwise; mem_addr/mem_we/mem_wdata are the registered values, stable for the whole transaction; mem_wdata is zero when mem_we=0.
REQ-022 In RX, mem_data_valid sampled high registers mem_rdata (reads only) into rsp_rdata; in DONE rsp_valid[owner] is high for exactly one cycle.
REQ-023 Latency: grant at cycle T, mem_req_valid from T+1, with mem_data_valid at T+2 rsp_valid at T+3; minimum 4 cycles per transaction, next grant earliest T+4.
REQ-024 RX wait counter starts at 0 on RX entry; if it reaches TIMEOUT_CYCLES without mem_data_valid, go to DONE with rsp_err=1 and rsp_rdata unchanged.
REQ-025 rsp_rdata holds its value until the next read completion.
REQ-026 stall high: state, counter, pointer and registered request hold; no new grant; mem outputs hold; mem_data_valid arriving in RX during stall is still captured.
REQ-027 flush high: next state IDLE, counter cleared, no rsp_valid for the aborted transaction, mem_req_valid low the following cycle; flush overrides stall.
REQ-028 req_valid deasserted after grant does not cancel the transaction.

Reset
REQ-029 reset: state IDLE, req_grant=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, mem_req_valid=0, mem_addr=0, mem_we=0, mem_wdata=0, counter=0, RR pointer=0; reset overrides flush and stall.

Configuration
REQ-030 ARB_ROUND_ROBIN_EN defined: round-robin priority; search starts at pointer, pointer = winner+1 mod NUM_PORTS after each grant.
REQ-031 ARB_ROUND_ROBIN_EN undefined: fixed priority, highest index wins (MMU over IFetch at NUM_PORTS=2); no pointer register.

Structure
REQ-032 Shared package arb_pkg holds the FSM state encoding (IDLE=2'b00, TX=2'b01, RX=2'b10, DONE=2'b11) and port-index width function.
REQ-033 Winner selection is sub-module arb_priority_pick (req vector, pointer in; one-hot grant, index out), purely combinational.

Verification
REQ-034 Port 2 read 0x100, mem_data_valid at T+2 with 0xDEADBEEF -> grant[2] at T, mem_addr=0x100, rsp_valid[2] and rsp_rdata=0xDEADBEEF at T+3.
REQ-035 All 4 ports request continuously with RR enabled -> grant order 0,1,2,3,0 every 4 cycles; without macro -> port 3 every time.
REQ-036 Port 1 write 0x55 to 0x20 -> mem_we=1, mem_wdata=0x55 during TX/RX; rsp_valid[1] with rsp_err=0, rsp_rdata unchanged.
REQ-037 TIMEOUT_CYCLES=4, no mem_data_valid -> rsp_valid and rsp_err=1 at cycle T+7, then IDLE.
REQ-038 flush in RX -> mem_req_valid=0 next cycle, no rsp_valid; stall 3 cycles in RX -> mem outputs held, completion delayed 3 cycles.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared definitions for the memory bus arbiter: FSM state encoding and
// the width helper for port indices.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    TX   = 2'b01,
    RX   = 2'b10,
    DONE = 2'b11
  } arb_state_t;

  // At least one bit so a two-port arbiter still has a usable index.
  function automatic int port_idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/arb_priority_pick.sv
// Combinational winner selection. Round-robin from ptr when
// ARB_ROUND_ROBIN_EN is defined, otherwise fixed priority (highest index wins).
module arb_priority_pick
  import arb_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int IDX_W     = port_idx_w(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     ptr,
  output logic [NUM_PORTS-1:0] grant,
  output logic [IDX_W-1:0]     idx
);

`ifdef ARB_ROUND_ROBIN_EN
  logic found;
  int   p;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    p     = 0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      p = int'(ptr) + k;
      if (p >= NUM_PORTS) p = p - NUM_PORTS;
      if (!found && req[p]) begin
        found = 1'b1;
        idx   = IDX_W'(p);
      end
    end
  end
`else
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  // Later assignments overwrite earlier ones, so the highest requester wins.
  always_comb begin
    idx = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (req[i]) idx = IDX_W'(i);
    end
  end
`endif

  assign grant = (|req) ? (NUM_PORTS'(1) << idx) : '0;

endmodule

// File: rtl/mem_bus_arbiter_n.sv
// N-port memory bus arbiter with a single outstanding transaction and RX timeout.
// Define ARB_ROUND_ROBIN_EN for round-robin priority; default is fixed priority.
module mem_bus_arbiter_n
  import arb_pkg::*;
#(
  parameter int NUM_PORTS      = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            flush,
  input  logic                            stall,
  input  logic [NUM_PORTS-1:0]            req_valid,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_PORTS-1:0]            req_we,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_PORTS-1:0]            req_grant,
  output logic [NUM_PORTS-1:0]            rsp_valid,
  output logic                            rsp_err,
  output logic [DATA_WIDTH-1:0]           rsp_rdata,
  output logic                            mem_req_valid,
  output logic [ADDR_WIDTH-1:0]           mem_addr,
  output logic                            mem_we,
  output logic [DATA_WIDTH-1:0]           mem_wdata,
  input  logic [DATA_WIDTH-1:0]           mem_rdata,
  input  logic                            mem_data_valid
);

  localparam int          IDX_W = port_idx_w(NUM_PORTS);
  localparam logic [15:0] TMO   = 16'(TIMEOUT_CYCLES);

  arb_state_t           state;
  logic [IDX_W-1:0]     rr_ptr;
  logic [IDX_W-1:0]     pick_idx;
  logic [IDX_W-1:0]     owner;
  logic [NUM_PORTS-1:0] pick_grant;
  logic [15:0]          wait_cnt;
  logic                 data_seen;
  logic                 grant_fire;

  arb_priority_pick #(.NUM_PORTS(NUM_PORTS), .IDX_W(IDX_W)) u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx)
  );

  assign grant_fire = (state == IDLE) && (|req_valid) && !stall && !flush && !reset;
  assign req_grant  = grant_fire ? pick_grant : '0;

`ifdef ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk) begin
    if (reset)
      rr_ptr <= '0;
    else if (grant_fire)
      rr_ptr <= (int'(pick_idx) == NUM_PORTS - 1) ? '0 : pick_idx + 1'b1;
  end
`else
  assign rr_ptr = '0;
`endif

  // data_seen remembers a response that arrived while stalled in RX.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      owner         <= '0;
      wait_cnt      <= '0;
      data_seen     <= 1'b0;
      rsp_valid     <= '0;
      rsp_err       <= 1'b0;
      rsp_rdata     <= '0;
      mem_req_valid <= 1'b0;
      mem_addr      <= '0;
      mem_we        <= 1'b0;
      mem_wdata     <= '0;
    end else begin
      rsp_valid <= '0;
      rsp_err   <= 1'b0;
      if (flush) begin
        state         <= IDLE;
        wait_cnt      <= '0;
        data_seen     <= 1'b0;
        mem_req_valid <= 1'b0;
      end else if (stall) begin
        if (state == RX && mem_data_valid && !data_seen) begin
          data_seen <= 1'b1;
          if (!mem_we) rsp_rdata <= mem_rdata;
        end
      end else begin
        case (state)
          IDLE: begin
            if (grant_fire) begin
              state         <= TX;
              owner         <= pick_idx;
              mem_req_valid <= 1'b1;
              mem_addr      <= req_addr[int'(pick_idx)*ADDR_WIDTH +: ADDR_WIDTH];
              mem_we        <= req_we[pick_idx];
              mem_wdata     <= req_we[pick_idx] ?
                               req_wdata[int'(pick_idx)*DATA_WIDTH +: DATA_WIDTH] : '0;
            end
          end
          TX: begin
            state    <= RX;
            wait_cnt <= '0;
          end
          RX: begin
            if (data_seen || mem_data_valid) begin
              state         <= DONE;
              data_seen     <= 1'b0;
              mem_req_valid <= 1'b0;
              rsp_valid     <= NUM_PORTS'(1) << owner;
              if (!data_seen && !mem_we) rsp_rdata <= mem_rdata;
            end else if (wait_cnt >= TMO) begin
              state         <= DONE;
              mem_req_valid <= 1'b0;
              rsp_valid     <= NUM_PORTS'(1) << owner;
              rsp_err       <= 1'b1;
            end else begin
              wait_cnt <= wait_cnt + 16'd1;
            end
          end
          DONE: begin
            state    <= IDLE;
            wait_cnt <= '0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter_n.sv
// Self-checking bench for mem_bus_arbiter_n: directed scenarios plus random
// transactions compared against a transaction-level reference model.
module tb_mem_bus_arbiter_n;
  import arb_pkg::*;

  localparam int NP  = 4;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 4;

  logic             clk = 1'b0;
  logic             reset, flush, stall;
  logic [NP-1:0]    req_valid, req_we;
  logic [NP*AW-1:0] req_addr;
  logic [NP*DW-1:0] req_wdata;
  logic [NP-1:0]    req_grant, rsp_valid;
  logic             rsp_err;
  logic [DW-1:0]    rsp_rdata;
  logic             mem_req_valid, mem_we, mem_data_valid;
  logic [AW-1:0]    mem_addr;
  logic [DW-1:0]    mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          m_ptr   = 0;
  logic [31:0] m_rdata = '0;
  logic [31:0] p_addr[NP];
  logic        p_we[NP];
  logic [31:0] p_wdata[NP];

  always #5 clk = ~clk;

  mem_bus_arbiter_n #(
    .NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush), .stall(stall),
    .req_valid(req_valid), .req_addr(req_addr), .req_we(req_we), .req_wdata(req_wdata),
    .req_grant(req_grant), .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .mem_req_valid(mem_req_valid), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_data_valid(mem_data_valid)
  );

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_ports();
    for (int i = 0; i < NP; i++) begin
      p_addr[i]  = $urandom;
      p_we[i]    = 1'($urandom_range(0, 1));
      p_wdata[i] = $urandom;
    end
  endtask

  task automatic apply_stimulus(input logic [NP-1:0] reqs);
    for (int i = 0; i < NP; i++) begin
      req_addr[i*AW +: AW]  = p_addr[i];
      req_we[i]             = p_we[i];
      req_wdata[i*DW +: DW] = p_wdata[i];
    end
    req_valid = reqs;
  endtask

  // Winner by the arbitration rule; advances the model pointer on a grant.
  task automatic model_grant(input logic [NP-1:0] reqs, output int w);
    w = -1;
`ifdef ARB_ROUND_ROBIN_EN
    for (int k = 0; k < NP; k++) begin
      if (w < 0 && reqs[(m_ptr + k) % NP]) w = (m_ptr + k) % NP;
    end
    if (w >= 0) m_ptr = (w + 1) % NP;
`else
    for (int i = NP - 1; i >= 0; i--) begin
      if (w < 0 && reqs[i]) w = i;
    end
`endif
  endtask

  // One complete transaction starting in an IDLE cycle; lat = RX cycle index
  // at which mem_data_valid arrives (lat > TMO means it never arrives).
  task automatic do_txn(input logic [NP-1:0] reqs, input int lat, input bit keep,
                        input logic [31:0] rd);
    int         w;
    logic [3:0] oh;
    bit         timeout;
    model_grant(reqs, w);
    oh      = 4'(1) << w;
    timeout = (lat > TMO);
    apply_stimulus(reqs);
    @(negedge clk);
    check_output("grant", 64'(req_grant), 64'(oh));
    check_output("mrv_idle", 64'(mem_req_valid), 64'd0);
    tick();
    if (!keep) req_valid = '0;
    @(negedge clk);
    check_output("tx_mrv", 64'(mem_req_valid), 64'd1);
    check_output("tx_addr", 64'(mem_addr), 64'(p_addr[w]));
    check_output("tx_we", 64'(mem_we), 64'(p_we[w]));
    check_output("tx_wdata", 64'(mem_wdata), p_we[w] ? 64'(p_wdata[w]) : 64'd0);
    check_output("tx_grant", 64'(req_grant), 64'd0);
    tick();
    for (int k = 0; k <= TMO; k++) begin
      if (k == lat) begin
        mem_data_valid = 1'b1;
        mem_rdata      = rd;
      end
      @(negedge clk);
      check_output("rx_mrv", 64'(mem_req_valid), 64'd1);
      check_output("rx_addr", 64'(mem_addr), 64'(p_addr[w]));
      check_output("rx_rsp", 64'(rsp_valid), 64'd0);
      tick();
      mem_data_valid = 1'b0;
      mem_rdata      = $urandom;
      if (k == lat) break;
    end
    if (!timeout && !p_we[w]) m_rdata = rd;
    @(negedge clk);
    check_output("done_rsp", 64'(rsp_valid), 64'(oh));
    check_output("done_err", 64'(rsp_err), 64'(timeout));
    check_output("done_rdata", 64'(rsp_rdata), 64'(m_rdata));
    check_output("done_mrv", 64'(mem_req_valid), 64'd0);
    check_output("done_grant", 64'(req_grant), 64'd0);
    tick();
    req_valid = keep ? reqs : '0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int w;
    reset = 1'b1; flush = 1'b0; stall = 1'b0;
    mem_data_valid = 1'b0; mem_rdata = '0;
    randomize_ports();
    apply_stimulus(4'b1111);
    tick(); tick();
    @(negedge clk);
    check_output("rst_grant", 64'(req_grant), 64'd0);
    check_output("rst_rsp", 64'(rsp_valid), 64'd0);
    check_output("rst_rdata", 64'(rsp_rdata), 64'd0);
    check_output("rst_mrv", 64'(mem_req_valid), 64'd0);
    check_output("rst_addr", 64'(mem_addr), 64'd0);
    req_valid = '0;
    reset = 1'b0;
    tick();

    // Port 2 read of 0x100 answered with 0xDEADBEEF
    randomize_ports();
    p_addr[2] = 32'h100; p_we[2] = 1'b0;
    do_txn(4'b0100, 0, 1'b0, 32'hDEADBEEF);

    // Port 1 write of 0x55 to 0x20
    randomize_ports();
    p_addr[1] = 32'h20; p_we[1] = 1'b1; p_wdata[1] = 32'h55;
    do_txn(4'b0010, 1, 1'b0, 32'h12345678);

    // All ports requesting continuously
    randomize_ports();
    for (int i = 0; i < 5; i++) do_txn(4'b1111, 0, 1'b1, $urandom);
    req_valid = '0;

    // Timeout with no memory response
    randomize_ports();
    p_we[0] = 1'b0;
    do_txn(4'b0001, TMO + 5, 1'b0, 32'h0);

    // Stall in IDLE blocks the grant
    stall = 1'b1;
    apply_stimulus(4'b0011);
    @(negedge clk);
    check_output("stall_idle_grant", 64'(req_grant), 64'd0);
    tick();
    stall = 1'b0;
    req_valid = '0;

    // Flush during RX aborts the transaction
    randomize_ports();
    model_grant(4'b0100, w);
    apply_stimulus(4'b0100);
    @(negedge clk);
    check_output("fl_grant", 64'(req_grant), 64'(4'b0100));
    tick();
    req_valid = '0;
    tick();
    flush = 1'b1;
    @(negedge clk);
    check_output("fl_rx_mrv", 64'(mem_req_valid), 64'd1);
    tick();
    flush = 1'b0;
    mem_data_valid = 1'b1; mem_rdata = 32'hBAD0BAD0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_output("fl_mrv", 64'(mem_req_valid), 64'd0);
      check_output("fl_rsp", 64'(rsp_valid), 64'd0);
      check_output("fl_rdata", 64'(rsp_rdata), 64'(m_rdata));
      tick();
    end
    mem_data_valid = 1'b0;

    // Stall 3 cycles in RX with the response arriving during the stall
    randomize_ports();
    p_we[0] = 1'b0;
    model_grant(4'b0001, w);
    apply_stimulus(4'b0001);
    @(negedge clk);
    check_output("st_grant", 64'(req_grant), 64'(4'b0001));
    tick();
    req_valid = '0;
    tick();
    stall = 1'b1; mem_data_valid = 1'b1; mem_rdata = 32'hCAFE0001;
    m_rdata = 32'hCAFE0001;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_output("st_mrv", 64'(mem_req_valid), 64'd1);
      check_output("st_addr", 64'(mem_addr), 64'(p_addr[0]));
      check_output("st_rsp", 64'(rsp_valid), 64'd0);
      tick();
      mem_data_valid = 1'b0; mem_rdata = $urandom;
    end
    stall = 1'b0;
    @(negedge clk);
    check_output("st_late_rsp", 64'(rsp_valid), 64'd0);
    tick();
    @(negedge clk);
    check_output("st_done_rsp", 64'(rsp_valid), 64'(4'b0001));
    check_output("st_done_rdata", 64'(rsp_rdata), 64'(m_rdata));
    check_output("st_done_err", 64'(rsp_err), 64'd0);
    tick();

    // Random transactions
    for (int n = 0; n < 25; n++) begin
      randomize_ports();
      do_txn(4'($urandom_range(1, 15)), $urandom_range(0, TMO + 1),
             1'($urandom_range(0, 1)), $urandom);
    end
    req_valid = '0;

    // Reset in the middle of traffic clears read data and pointer
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_ptr = 0; m_rdata = '0;
    @(negedge clk);
    check_output("rst2_rdata", 64'(rsp_rdata), 64'd0);
    tick();
    randomize_ports();
    do_txn(4'b1111, 0, 1'b0, $urandom);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
